// File: rtl/alu64_sequencer.sv
// alu64_sequencer: runs one 64-bit ALU operation as two passes (low half, then high half)
// over a shared HALF_W-bit ALU, chaining carry/borrow between the passes.
// Ports:
//   clk, rst                      clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready           request handshake; req_cmd, req_a, req_b, req_cin payload
//   rsp_valid/rsp_ready           response handshake; rsp_result, rsp_n/z/c/v, rsp_err payload
//   alu_in1, alu_in2, alu_cmd,    registered drive into the ALU
//   alu_cin
//   alu_out, alu_cout, alu_v,     combinational results from the ALU
//   alu_n, alu_z
module alu64_sequencer #(
   parameter int unsigned HALF_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [3:0]          req_cmd,
   input  logic [2*HALF_W-1:0] req_a,
   input  logic [2*HALF_W-1:0] req_b,
   input  logic                req_cin,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [2*HALF_W-1:0] rsp_result,
   output logic                rsp_n,
   output logic                rsp_z,
   output logic                rsp_c,
   output logic                rsp_v,
   output logic                rsp_err,
   output logic [HALF_W-1:0]   alu_in1,
   output logic [HALF_W-1:0]   alu_in2,
   output logic [3:0]          alu_cmd,
   output logic                alu_cin,
   input  logic [HALF_W-1:0]   alu_out,
   input  logic                alu_cout,
   input  logic                alu_v,
   input  logic                alu_n,
   input  logic                alu_z
);
   localparam int unsigned W = 2 * HALF_W;

   localparam logic [3:0] CMD_NOP = 4'b0000;
   localparam logic [3:0] CMD_ADD = 4'b0010;
   localparam logic [3:0] CMD_ADC = 4'b0011;
   localparam logic [3:0] CMD_SUB = 4'b0100;
   localparam logic [3:0] CMD_SBC = 4'b0101;

   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

   state_t            state, state_d;
   logic [3:0]        cmd_q, cmd_d;
   logic [HALF_W-1:0] a_hi_q, a_hi_d, b_hi_q, b_hi_d;
   logic [HALF_W-1:0] res_lo_q, res_lo_d;
   logic              z_lo_q, z_lo_d;

   logic              req_ready_d, rsp_valid_d;
   logic [W-1:0]      rsp_result_d;
   logic              rsp_n_d, rsp_z_d, rsp_c_d, rsp_v_d, rsp_err_d;
   logic [HALF_W-1:0] alu_in1_d, alu_in2_d;
   logic [3:0]        alu_cmd_d;
   logic              alu_cin_d;

   function automatic logic is_supported(input logic [3:0] cmd);
      case (cmd)
         4'b0001, CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC,
         4'b0110, 4'b0111, 4'b1000, 4'b1001: return 1'b1;
         default:                             return 1'b0;
      endcase
   endfunction

   function automatic logic is_add(input logic [3:0] cmd);
      return (cmd == CMD_ADD) || (cmd == CMD_ADC);
   endfunction

   function automatic logic is_sub(input logic [3:0] cmd);
      return (cmd == CMD_SUB) || (cmd == CMD_SBC);
   endfunction

   // High pass always uses the carry-aware form of add/subtract
   function automatic logic [3:0] hi_cmd(input logic [3:0] cmd);
      if (!is_supported(cmd)) return CMD_NOP;
      if (is_add(cmd))        return CMD_ADC;
      if (is_sub(cmd))        return CMD_SBC;
      return cmd;
   endfunction

   // State register plus all registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cmd_q      <= CMD_NOP;
         a_hi_q     <= '0;
         b_hi_q     <= '0;
         res_lo_q   <= '0;
         z_lo_q     <= 1'b0;
         req_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         rsp_n      <= 1'b0;
         rsp_z      <= 1'b0;
         rsp_c      <= 1'b0;
         rsp_v      <= 1'b0;
         rsp_err    <= 1'b0;
         alu_in1    <= '0;
         alu_in2    <= '0;
         alu_cmd    <= CMD_NOP;
         alu_cin    <= 1'b0;
      end else begin
         state      <= state_d;
         cmd_q      <= cmd_d;
         a_hi_q     <= a_hi_d;
         b_hi_q     <= b_hi_d;
         res_lo_q   <= res_lo_d;
         z_lo_q     <= z_lo_d;
         req_ready  <= req_ready_d;
         rsp_valid  <= rsp_valid_d;
         rsp_result <= rsp_result_d;
         rsp_n      <= rsp_n_d;
         rsp_z      <= rsp_z_d;
         rsp_c      <= rsp_c_d;
         rsp_v      <= rsp_v_d;
         rsp_err    <= rsp_err_d;
         alu_in1    <= alu_in1_d;
         alu_in2    <= alu_in2_d;
         alu_cmd    <= alu_cmd_d;
         alu_cin    <= alu_cin_d;
      end
   end

   // Next state; ALU drive values are loaded one edge ahead of the pass that uses them
   always_comb begin
      state_d      = state;
      cmd_d        = cmd_q;
      a_hi_d       = a_hi_q;
      b_hi_d       = b_hi_q;
      res_lo_d     = res_lo_q;
      z_lo_d       = z_lo_q;
      req_ready_d  = req_ready;
      rsp_valid_d  = rsp_valid;
      rsp_result_d = rsp_result;
      rsp_n_d      = rsp_n;
      rsp_z_d      = rsp_z;
      rsp_c_d      = rsp_c;
      rsp_v_d      = rsp_v;
      rsp_err_d    = rsp_err;
      alu_in1_d    = '0;
      alu_in2_d    = '0;
      alu_cmd_d    = CMD_NOP;
      alu_cin_d    = 1'b0;

      case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               state_d     = LO;
               req_ready_d = 1'b0;
               cmd_d       = req_cmd;
               a_hi_d      = req_a[W-1:HALF_W];
               b_hi_d      = req_b[W-1:HALF_W];
               alu_in1_d   = req_a[HALF_W-1:0];
               alu_in2_d   = req_b[HALF_W-1:0];
               alu_cmd_d   = is_supported(req_cmd) ? req_cmd : CMD_NOP;
               alu_cin_d   = ((req_cmd == CMD_ADC) || (req_cmd == CMD_SBC)) ? req_cin : 1'b0;
            end
         end
         LO: begin
            state_d   = HI;
            res_lo_d  = alu_out;
            z_lo_d    = alu_z;
            alu_in1_d = a_hi_q;
            alu_in2_d = b_hi_q;
            alu_cmd_d = hi_cmd(cmd_q);
            // ALU reports borrow on subtract while SBC wants "no borrow" as carry-in
            if (is_add(cmd_q))      alu_cin_d = alu_cout;
            else if (is_sub(cmd_q)) alu_cin_d = ~alu_cout;
         end
         HI: begin
            state_d     = DONE;
            rsp_valid_d = 1'b1;
            if (is_supported(cmd_q)) begin
               rsp_result_d = {alu_out, res_lo_q};
               rsp_n_d      = alu_n;
               rsp_z_d      = z_lo_q & alu_z;
               rsp_c_d      = (is_add(cmd_q) || is_sub(cmd_q)) ? alu_cout : 1'b0;
               rsp_v_d      = (is_add(cmd_q) || is_sub(cmd_q)) ? alu_v : 1'b0;
               rsp_err_d    = 1'b0;
            end else begin
               rsp_result_d = '0;
               rsp_n_d      = 1'b0;
               rsp_z_d      = 1'b1;
               rsp_c_d      = 1'b0;
               rsp_v_d      = 1'b0;
               rsp_err_d    = 1'b1;
            end
         end
         DONE: begin
            if (rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
               req_ready_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_alu64_sequencer.sv
// tb_alu64_sequencer: directed bench for alu64_sequencer with a behavioural 32-bit ALU
// attached to the sequencer's ALU port.
module tb_alu64_sequencer;
   localparam int unsigned HALF_W = 32;
   localparam int unsigned W      = 2 * HALF_W;

   logic              clk, rst;
   logic              req_valid, req_ready, req_cin;
   logic [3:0]        req_cmd;
   logic [W-1:0]      req_a, req_b;
   logic              rsp_valid, rsp_ready;
   logic [W-1:0]      rsp_result;
   logic              rsp_n, rsp_z, rsp_c, rsp_v, rsp_err;
   logic [HALF_W-1:0] alu_in1, alu_in2, alu_out;
   logic [3:0]        alu_cmd;
   logic              alu_cin, alu_cout, alu_v, alu_n, alu_z;

   int n_checks = 0;
   int n_pass   = 0;

   logic [3:0] lo_cmd, hi_cmd;
   logic       lo_cin, hi_cin;
   int         lat;

   alu64_sequencer #(.HALF_W(HALF_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
      .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_n(rsp_n), .rsp_z(rsp_z), .rsp_c(rsp_c), .rsp_v(rsp_v), .rsp_err(rsp_err),
      .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_cmd(alu_cmd), .alu_cin(alu_cin),
      .alu_out(alu_out), .alu_cout(alu_cout), .alu_v(alu_v), .alu_n(alu_n), .alu_z(alu_z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU: cout is borrow on subtract; SBC cin=1 means no borrow
   logic [HALF_W:0] m_sum;
   always_comb begin
      m_sum    = '0;
      alu_out  = '0;
      alu_cout = 1'b0;
      alu_v    = 1'b0;
      case (alu_cmd)
         4'b0010, 4'b0011: begin
            m_sum    = {1'b0, alu_in1} + {1'b0, alu_in2} +
                       {{HALF_W{1'b0}}, (alu_cmd == 4'b0011) & alu_cin};
            alu_out  = m_sum[HALF_W-1:0];
            alu_cout = m_sum[HALF_W];
            alu_v    = (alu_in1[HALF_W-1] == alu_in2[HALF_W-1]) &&
                       (alu_out[HALF_W-1] != alu_in1[HALF_W-1]);
         end
         4'b0100, 4'b0101: begin
            m_sum    = {1'b0, alu_in1} - {1'b0, alu_in2} -
                       {{HALF_W{1'b0}}, (alu_cmd == 4'b0101) & ~alu_cin};
            alu_out  = m_sum[HALF_W-1:0];
            alu_cout = m_sum[HALF_W];
            alu_v    = (alu_in1[HALF_W-1] != alu_in2[HALF_W-1]) &&
                       (alu_out[HALF_W-1] != alu_in1[HALF_W-1]);
         end
         4'b0001: alu_out = alu_in1;
         4'b0110: alu_out = alu_in1 & alu_in2;
         4'b0111: alu_out = alu_in1 | alu_in2;
         4'b1000: alu_out = alu_in1 ^ alu_in2;
         4'b1001: alu_out = ~alu_in1;
         default: alu_out = '0;
      endcase
   end
   assign alu_n = alu_out[HALF_W-1];
   assign alu_z = (alu_out == '0);

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [4:0] flags();
      return {rsp_n, rsp_z, rsp_c, rsp_v, rsp_err};
   endfunction

   task automatic issue(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin);
      @(negedge clk);
      req_valid = 1'b1;
      req_cmd   = cmd;
      req_a     = a;
      req_b     = b;
      req_cin   = cin;
   endtask

   // Bounded wait for rsp_valid; records the ALU drive seen in the first two cycles
   task automatic wait_rsp(output int cycles);
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
         if (cycles == 1) begin
            req_valid = 1'b0;
            lo_cmd    = alu_cmd;
            lo_cin    = alu_cin;
         end
         if (cycles == 2) begin
            hi_cmd = alu_cmd;
            hi_cin = alu_cin;
         end
      end while (!rsp_valid && cycles < 12);
      if (!rsp_valid) check("rsp_timeout", W'(rsp_valid), W'(1));
   endtask

   task automatic handshake();
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic run_op(input string tag, input logic [3:0] cmd, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic cin,
                         input logic [W-1:0] exp_res, input logic [4:0] exp_flags);
      issue(cmd, a, b, cin);
      wait_rsp(lat);
      check({tag, "_lat"}, W'(lat), W'(3));
      check({tag, "_res"}, rsp_result, exp_res);
      check({tag, "_flags"}, W'(flags()), W'(exp_flags));
      handshake();
   endtask

   initial begin
      logic seen;
      rst = 1'b1; req_valid = 1'b0; req_cmd = '0; req_a = '0; req_b = '0;
      req_cin = 1'b0; rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_req_ready", W'(req_ready), W'(1));
      check("rst_rsp_valid", W'(rsp_valid), W'(0));
      check("rst_result", rsp_result, '0);
      check("rst_flags", W'(flags()), W'(0));
      check("rst_alu", {alu_in1, alu_in2}, '0);
      check("rst_alu_cmd_cin", W'({alu_cmd, alu_cin}), W'(0));
      rst = 1'b0;

      // Carry from low into high half
      run_op("add_carry", 4'b0010, 64'h00000000_FFFFFFFF, 64'h1, 1'b0,
             64'h00000001_00000000, 5'b00000);
      check("add_lo_cmd", W'(lo_cmd), W'(4'b0010));
      check("add_hi_cmd", W'(hi_cmd), W'(4'b0011));
      check("add_hi_cin", W'(hi_cin), W'(1));

      // Signed overflow into the sign bit
      run_op("add_ovf", 4'b0010, 64'h7FFFFFFF_FFFFFFFF, 64'h1, 1'b0,
             64'h80000000_00000000, 5'b10010);

      // Subtract with borrow out of the top
      run_op("sub_borrow", 4'b0100, 64'h0, 64'h1, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 5'b10100);
      run_op("sub_chain", 4'b0100, 64'h00000001_00000000, 64'h1, 1'b0,
             64'h00000000_FFFFFFFF, 5'b00000);
      check("sub_hi_cmd", W'(hi_cmd), W'(4'b0101));
      check("sub_hi_cin", W'(hi_cin), W'(0));

      // Backpressure: response held, a waiting request is not taken
      issue(4'b1000, 64'h12345678_9ABCDEF0, 64'h12345678_9ABCDEF0, 1'b0);
      wait_rsp(lat);
      req_valid = 1'b1; req_cmd = 4'b0010; req_a = 64'h1; req_b = 64'h1; req_cin = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("bp_result", rsp_result, '0);
         check("bp_flags", W'(flags()), W'(5'b01000));
         check("bp_valid_ready", W'({rsp_valid, req_ready}), W'(2'b10));
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("bp_idle_ready", W'({rsp_valid, req_ready}), W'(2'b01));
      check("bp_result_held", rsp_result, '0);
      @(negedge clk);
      check("bp_accepted", W'(req_ready), W'(0));
      wait_rsp(lat);
      check("bp_next_res", rsp_result, 64'h2);
      handshake();

      // Unsupported command, then a normal one
      run_op("bad_cmd", 4'b1111, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0,
             64'h0, 5'b01001);
      check("bad_lo_cmd", W'(lo_cmd), W'(4'b0000));
      run_op("add_after_bad", 4'b0010, 64'h1, 64'h1, 1'b0, 64'h2, 5'b00000);

      // Reset during the high pass
      issue(4'b0010, 64'h5, 64'h7, 1'b0);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      check("rst_hi_pre_cmd", W'(alu_cmd), W'(4'b0011));
      rst = 1'b1;
      #1;
      check("rst_hi_valid_ready", W'({rsp_valid, req_ready}), W'(2'b01));
      check("rst_hi_alu_cmd", W'(alu_cmd), W'(0));
      check("rst_hi_result", rsp_result, '0);
      @(negedge clk);
      rst  = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         seen |= rsp_valid;
      end
      check("rst_no_rsp", W'(seen), W'(0));

      // Carry-in honoured on the low pass
      run_op("adc_cin", 4'b0011, 64'h5, 64'h6, 1'b1, 64'hC, 5'b00000);
      check("adc_lo_cin", W'(lo_cin), W'(1));
      run_op("sbc_cin", 4'b0101, 64'h10, 64'h5, 1'b0, 64'hA, 5'b00000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/alu64_sequencer.md
Name: alu64_sequencer

Overview:
- Multi-cycle controller that performs 64-bit arithmetic and logic operations on the shared 32-bit ALU.
- Issues the low half in one cycle, then the high half in the next, chaining carry/borrow between halves.
- Returns a 64-bit result plus N/Z/C/V through a valid/ready response port.
- Sits between the execute-stage issue logic and the ALU instance; drives the ALU's operand, command and carry-in inputs directly.

Parameters:
HALF_W, 32, width of one ALU pass; operands and result are 2*HALF_W.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  sequencer can accept a request
req_cmd  input  4  ALU command code (same encoding as ALU)
req_a  input  2*HALF_W  operand 1
req_b  input  2*HALF_W  operand 2
req_cin  input  1  carry-in for ADC/SBC low half
rsp_valid  output  1  result available
rsp_ready  input  1  consumer accepts result
rsp_result  output  2*HALF_W  64-bit result
rsp_n, rsp_z, rsp_c, rsp_v  output  1 each  flags
rsp_err  output  1  unsupported command
alu_in1, alu_in2  output  HALF_W  ALU operands
alu_cmd  output  4  ALU command
alu_cin  output  1  ALU carry-in
alu_out  input  HALF_W  ALU result (combinational)
alu_cout, alu_v, alu_n, alu_z  input  1 each  ALU flags (combinational)

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values: state IDLE; req_ready=1; rsp_valid=0; rsp_result=0; all rsp flags 0; rsp_err=0; alu_in1/in2=0; alu_cmd=0000; alu_cin=0.
- FSM states:
  - IDLE: req_ready=1. On req_valid&req_ready, capture cmd/a/b/cin and go to LO.
  - LO: drive low halves.
    - Sample alu_out → res_lo, alu_cout → c_lo, alu_z → z_lo at the clock edge.
    - Go to HI.
  - HI: drive high halves.
    - Sample alu_out → res_hi and high-half flags.
    - Go to DONE.
  - DONE: rsp_valid=1; outputs held stable. On rsp_ready, go to IDLE.
- req_ready is 1 only in IDLE; no request is accepted while busy or holding a response.
- Latency: accept at edge 0, LO cycle 1, HI cycle 2; rsp_valid asserted from cycle 3. Throughput is one op per 4 cycles minimum.
- ALU drive outside LO/HI: alu_in1=alu_in2=0, alu_cmd=0000, alu_cin=0.
- Command mapping (low cmd / high cmd / high alu_cin):
  - 0010 ADD: 0010 / 0011 / c_lo
  - 0011 ADC: 0011 (alu_cin=req_cin) / 0011 / c_lo
  - 0100 SUB: 0100 / 0101 / ~c_lo
  - 0101 SBC: 0101 (alu_cin=req_cin) / 0101 / ~c_lo
  - 0001, 1001, 0110, 0111, 1000: same cmd both halves; alu_cin=0
- Carry conventions: for subtract, ALU cout=1 means borrow, and SBC carry_in=1 means no borrow; hence the inverted chaining.
- Flags:
  - rsp_n = high-half alu_n.
  - rsp_z = z_lo & high-half alu_z.
  - rsp_c = high-half alu_cout, which is borrow for SUB/SBC.
  - rsp_v = high-half alu_v.
  - Logic ops: rsp_c=0, rsp_v=0.
- Unsupported req_cmd (any other code):
  - Accepted and still sequenced through LO/HI with alu_cmd=0000.
  - Response: result 0, N=0, Z=1, C=0, V=0, rsp_err=1.
  - rsp_err=0 for every supported cmd.
- Response port: rsp_result, flags and err change only on the transition into DONE. They hold until the next op's DONE; they are not cleared on handshake.
- Reset mid-operation (any state): immediate return to reset values; partial results are discarded and no response is produced.
- req_valid while busy is ignored; the requester must hold it.

Test Plan:
- ADD a=0x00000000_FFFFFFFF, b=1 → rsp_valid at cycle 3, result 0x00000001_00000000, N=0 Z=0 C=0 V=0; alu_cin=1 during HI.
- ADD a=0x7FFFFFFF_FFFFFFFF, b=1 → result 0x80000000_00000000, N=1 V=1 C=0 Z=0.
- SUB a=0, b=1 → result 0xFFFFFFFF_FFFFFFFF, N=1 C=1 Z=0. Then SUB a=0x00000001_00000000, b=1 → 0x00000000_FFFFFFFF, C=0; alu_cmd=0101 with alu_cin=0 in HI.
- Backpressure: XOR a=b=0x12345678_9ABCDEF0 with rsp_ready=0 for 5 cycles → result 0, Z=1 held stable; req_ready=0 and a waiting req_valid is not accepted until the cycle after rsp_ready=1.
- Unsupported cmd 1111, a=b=0xFFFF_FFFF_FFFF_FFFF → result 0, Z=1, rsp_err=1; a following ADD 1+1 gives 2 with rsp_err=0.
- Assert rst during HI of an ADD → same cycle: rsp_valid=0, req_ready=1, alu_cmd=0000; no response after release; the next request completes normally.
